// File: rtl/prime_filter_fifo.sv
// Prime filter FIFO: queues candidates flagged prime, drops composites,
// and keeps saturating accept statistics.
module prime_filter_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_n,
  input  logic                       in_is_prime,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_n,
  output logic [CNT_W-1:0]           prime_cnt,
  output logic [CNT_W-1:0]           total_cnt,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              accept;
  logic              push;
  logic              pop;

  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign out_n     = mem[rd_ptr];

  assign accept = in_valid & in_ready;
  assign push   = accept & in_is_prime;
  assign pop    = out_valid & out_ready;

  // Storage holds whatever it had; only pointers/count define contents.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= in_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      prime_cnt <= '0;
      total_cnt <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      prime_cnt <= '0;
      total_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (accept && total_cnt != '1) begin
        total_cnt <= total_cnt + CNT_W'(1);
      end
      if (push && prime_cnt != '1) begin
        prime_cnt <= prime_cnt + CNT_W'(1);
      end
    end
  end

endmodule
